// File: rtl/sram_dual_ctrl_if.sv
// sram_dual_ctrl_if: CPU-side word request bus (req/we/be/addr/wdata in, ready/done out).
interface sram_dual_ctrl_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    modport master (output req, we, be, addr, wdata, input ready, done);
    modport slave  (input req, we, be, addr, wdata, output ready, done);
endinterface

// File: rtl/sram_dual_ctrl.sv
// sram_dual_ctrl: sequences one CPU word access at a time onto the base/ext async SRAMs; ports: clk, rst, bus (request handshake), base_/ext_rdata holding registers, seven pin signals per SRAM.
module sram_dual_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    sram_dual_ctrl_if.slave   bus,
    output logic [31:0]       base_rdata,
    output logic [31:0]       ext_rdata,
    output logic [ADDR_W-1:0] base_ram_addr,
    output logic [3:0]        base_ram_be_n,
    output logic              base_ram_ce_n,
    output logic              base_ram_oe_n,
    output logic              base_ram_we_n,
    output logic [31:0]       base_ram_wdata,
    output logic              base_ram_data_oe,
    input  logic [31:0]       base_ram_rdata,
    output logic [ADDR_W-1:0] ext_ram_addr,
    output logic [3:0]        ext_ram_be_n,
    output logic              ext_ram_ce_n,
    output logic              ext_ram_oe_n,
    output logic              ext_ram_we_n,
    output logic [31:0]       ext_ram_wdata,
    output logic              ext_ram_data_oe,
    input  logic [31:0]       ext_ram_rdata
);
    localparam int W = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam logic [3:0] W_M1 = 4'(W - 1);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic r_we, r_bank, acc, cap, n_we, n_bank;
    logic [3:0] r_be, n_be;
    logic [1:0] sel, ce_n_d, oe_n_d, we_n_d, doe_d, ce_n_q, oe_n_q, we_n_q, doe_q;
    logic [1:0][3:0] be_n_d, be_n_q;
    logic [1:0][ADDR_W-1:0] addr_q;
    logic [1:0][31:0] wdata_q;
    logic unused_ok;
    assign unused_ok = ^{bus.addr[31:23], bus.addr[1:0]};
    always_comb begin
        acc = state == IDLE && bus.ready && bus.req;
        cap = state == ACCESS && cnt == 4'd0 && !r_we;
        n_we = acc ? bus.we : r_we;
        n_bank = acc ? bus.addr[22] : r_bank;
        n_be = acc ? bus.be : r_be;
        state_n = state;
        cnt_n = cnt;
        unique case (state)
            IDLE:   state_n = acc ? SETUP : IDLE;
            SETUP:  begin state_n = ACCESS; cnt_n = W_M1; end
            ACCESS: begin state_n = cnt == 4'd0 ? DONE : ACCESS; cnt_n = cnt - 4'd1; end
            DONE:   state_n = IDLE;
        endcase
        // Pin values are computed for the state being entered so they are registered in step with it.
        for (int b = 0; b < 2; b++) begin
            sel[b] = n_bank == 1'(b);
            ce_n_d[b] = !(sel[b] && (state_n == SETUP || state_n == ACCESS));
            oe_n_d[b] = ce_n_d[b] || n_we;
            we_n_d[b] = !(sel[b] && n_we && state_n == ACCESS);
            be_n_d[b] = ce_n_d[b] ? 4'hF : ~n_be;
            // Write data stays on the pad through DONE for hold time.
            doe_d[b] = sel[b] && n_we && state_n != IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            bus.ready <= 1'b0;
            bus.done <= 1'b0;
            r_we <= 1'b0;
            r_bank <= 1'b0;
            r_be <= '0;
            base_rdata <= '0;
            ext_rdata <= '0;
            ce_n_q <= 2'b11;
            oe_n_q <= 2'b11;
            we_n_q <= 2'b11;
            doe_q <= 2'b00;
            be_n_q <= {2{4'hF}};
            addr_q <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bus.ready <= state_n == IDLE;
            bus.done <= state_n == DONE;
            if (acc) begin
                r_we <= bus.we;
                r_bank <= bus.addr[22];
                r_be <= bus.be;
            end
            if (cap && !r_bank) base_rdata <= base_ram_rdata;
            if (cap && r_bank) ext_rdata <= ext_ram_rdata;
            ce_n_q <= ce_n_d;
            oe_n_q <= oe_n_d;
            we_n_q <= we_n_d;
            doe_q <= doe_d;
            be_n_q <= be_n_d;
            for (int b = 0; b < 2; b++) begin
                if (acc && sel[b]) begin
                    addr_q[b] <= bus.addr[2 +: ADDR_W];
                    wdata_q[b] <= bus.wdata;
                end
            end
        end
    end
    assign base_ram_addr    = addr_q[0];
    assign base_ram_be_n    = be_n_q[0];
    assign base_ram_ce_n    = ce_n_q[0];
    assign base_ram_oe_n    = oe_n_q[0];
    assign base_ram_we_n    = we_n_q[0];
    assign base_ram_wdata   = wdata_q[0];
    assign base_ram_data_oe = doe_q[0];
    assign ext_ram_addr     = addr_q[1];
    assign ext_ram_be_n     = be_n_q[1];
    assign ext_ram_ce_n     = ce_n_q[1];
    assign ext_ram_oe_n     = oe_n_q[1];
    assign ext_ram_we_n     = we_n_q[1];
    assign ext_ram_wdata    = wdata_q[1];
    assign ext_ram_data_oe  = doe_q[1];
endmodule

// File: doc/sram_dual_ctrl.md
Name: sram_dual_ctrl

Overview:
- FSM controller for the board's two asynchronous 32-bit SRAMs, base and ext.
- Accepts one word request at a time from the CPU-side bus, then sequences CE/OE/WE/BE, address and data on the selected chip.
- Registers read data into per-bank holding registers, base_rdata and ext_rdata.
- These registers feed the downstream SRAM read-data crossing stage on its write side.

Parameters:
WAIT_CYCLES, 2, number of ACCESS cycles with strobe active; legal range 1..15, and a value of 0 is treated as 1.
ADDR_W, 20, SRAM word-address width.

Ports:
clk  in  1  single clock
rst  in  1  asynchronous reset, active-high
req  in  1  request valid
we  in  1  1=write, 0=read
be  in  4  byte enables, active-high
addr  in  32  byte address; addr[22] selects bank (0=base, 1=ext); addr[21:2] is the word address
wdata  in  32  write data
ready  out  1  controller idle; a request is accepted this cycle if req=1
done  out  1  one-cycle completion pulse
base_rdata  out  32  last word read from base SRAM (held)
ext_rdata  out  32  last word read from ext SRAM (held)
base_ram_addr  out  ADDR_W  SRAM word address
base_ram_be_n  out  4  byte enables, active-low
base_ram_ce_n, base_ram_oe_n, base_ram_we_n  out  1 each  chip strobes, active-low
base_ram_wdata  out  32  data driven to pad
base_ram_data_oe  out  1  pad output enable (top level builds the tristate)
base_ram_rdata  in  32  data from pad
ext_ram_*  identical set of seven ports for the ext SRAM

Behaviour:
- All outputs registered.
- While rst=1, asynchronously and immediately:
  - state=IDLE, ready=0, done=0;
  - base_rdata=ext_rdata=0;
  - all ce_n/oe_n/we_n=1, be_n=4'hF, data_oe=0, ram_addr=0, ram_wdata=0.
- ready rises on the first clk edge after rst falls.
- States: IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles, down-counter) -> DONE -> IDLE.
- IDLE:
  - ready=1.
  - At an edge with req=1, the request is accepted: we/be/addr/wdata latched, ready->0, state->SETUP.
  - req while ready=0 is ignored, not queued.
- Cycle numbering: the accept edge ends cycle 0.
  - SETUP = cycle 1.
  - ACCESS = cycles 2..1+W.
  - DONE = cycle 2+W, with done=1.
  - IDLE = cycle 3+W.
  - Back-to-back accept spacing = W+3 cycles (5 at default).
- Read, selected bank:
  - SETUP and ACCESS: ce_n=0, oe_n=0, be_n=~be, addr driven, data_oe=0.
  - At the edge ending the last ACCESS cycle, ram_rdata is captured into that bank's rdata register.
  - DONE: ce_n=oe_n=1.
  - The other bank's rdata register is unchanged.
- Write, selected bank:
  - SETUP: ce_n=0, addr/wdata/be_n driven, data_oe=1, we_n=1.
  - ACCESS: we_n=0.
  - DONE: we_n=1, ce_n=1; addr/wdata/data_oe held for hold time.
  - IDLE: data_oe=0.
  - rdata registers are unchanged on a write.
- The non-selected bank's strobes stay inactive (=1), with be_n=4'hF and data_oe=0, for the whole transaction.
- Invariants:
  - oe_n and we_n are never both 0.
  - data_oe=1 never coincides with oe_n=0.
  - done=1 only in DONE.
- Write with be=4'h0: full cycle still runs with be_n=4'hF, and done pulses.
- Reset mid-transaction: the request is dropped, no done pulse, and pins go inactive asynchronously.

Test Plan:
1. Read base, addr=0x8000_0010, base_ram_rdata=0xDEADBEEF -> base_ram_addr=0x00004; ce_n/oe_n low in cycles 1-3; done=1 in cycle 4; base_rdata=0xDEADBEEF, ext_rdata=0; ready=1 in cycle 5.
2. Write ext, addr=0x8040_0008, wdata=0x12345678, be=4'b0011 -> ext_ram_addr=0x00002, be_n=4'b1100; we_n low exactly in cycles 2-3; data_oe=1 in cycles 1-4; base pins inactive throughout; no rdata change.
3. req held high for two reads (base then ext) -> accepts exactly 5 cycles apart; each bank register holds its own word; no overlap of strobes between banks.
4. req pulsed during ACCESS of a read -> ignored; exactly one done pulse; state returns to IDLE.
5. rst asserted in ACCESS of a write -> we_n/ce_n=1 and data_oe=0 without waiting for clk; no done; rdata=0; ready=1 one edge after release.
6. WAIT_CYCLES=4, read base -> oe_n low in cycles 1-5; done in cycle 6; accept spacing 7 cycles.
